// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor. One 4-bit carry-look-ahead slice
//   is reused once per cycle, least-significant nibble first. The carry
//   between nibbles is held in a register, and the result is assembled in
//   place. An operation takes N = WIDTH/4 cycles from start to done.
//
// Ports
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset
//   i_start  request an operation (sampled only when idle)
//   i_sub    0: A+B, 1: A-B (sampled with i_start)
//   i_a/i_b  operands (sampled with i_start)
//   o_busy   operation in progress
//   o_done   one-cycle completion pulse; results valid from then on
//   o_sum    result, two's-complement wrap
//   o_cout   carry out of the MSB (for subtract: 1 = no borrow)
//   o_ovf    signed overflow
//   o_zero   result is zero

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {StIdle, StRun} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_slice_sum;
  logic [WIDTH-1:0] w_result_next;
  logic             w_c_into_msb;

  // Bit offset of the active nibble is simply index * 4.
  assign w_nib_a = r_op_a[{r_idx, 2'b00} +: 4];
  assign w_nib_b = r_op_b[{r_idx, 2'b00} +: 4];

  // 4-bit carry-look-ahead slice: every carry is a flat G/P expression of c0.
  always_comb begin
    w_g    = w_nib_a & w_nib_b;
    w_p    = w_nib_a ^ w_nib_b;
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_slice_sum = w_p ^ w_c[3:0];
  end

  // Result register with the current nibble merged in; on the last nibble
  // this is the complete sum.
  always_comb begin
    w_result_next = r_result;
    w_result_next[{r_idx, 2'b00} +: 4] = w_slice_sum;
  end

  // Sum bit = a ^ b ^ cin, so cin of the MSB falls out of the three known bits.
  assign w_c_into_msb = r_op_a[WIDTH-1] ^ r_op_b[WIDTH-1] ^ w_result_next[WIDTH-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_op_a  <= i_a;
            r_op_b  <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub;  // the +1 of two's-complement subtract
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_result <= w_result_next;
          r_carry  <= w_c[4];
          r_idx    <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            r_sum   <= w_result_next;
            r_cout  <= w_c[4];
            r_ovf   <= w_c_into_msb ^ w_c[4];
            r_zero  <= (w_result_next == '0);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;
  assign o_zero = r_zero;

endmodule
